// File: rtl/wb_pkg.sv
// Shared types and constants for the register-file write-back initiator.
// The FSM encoding stays as plain localparams so legacy blocks can decode it.
package wb_pkg;

    localparam int REG_AW   = 5;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 1 << REG_AW;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

    typedef logic [1:0] wb_state_t;

    localparam wb_state_t ST_IDLE    = 2'd0;
    localparam wb_state_t ST_WRITE   = 2'd1;
    localparam wb_state_t ST_RELEASE = 2'd2;

    function automatic logic [NUM_REGS-1:0] rd_onehot(input logic [REG_AW-1:0] rd);
        rd_onehot     = '0;
        rd_onehot[rd] = 1'b1;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Circular write-back buffer: two pushes (slot 0 lands ahead of slot 1), one pop.
// Publishes count plus per-slot valid/rd so the owner can build a pending mask.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push0_en,
    input  wb_entry_t                     push0_entry,
    input  logic                          push1_en,
    input  wb_entry_t                     push1_entry,
    input  logic                          pop_en,
    output wb_entry_t                     head,
    output logic [CW-1:0]                 count,
    output logic [DEPTH-1:0]              entry_valid,
    output logic [DEPTH-1:0][REG_AW-1:0]  entry_rd
);

    wb_entry_t             mem_q [DEPTH];
    wb_entry_t             mem_d [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [PTR_W-1:0]      push1_idx;
    logic [DEPTH-1:0][PTR_W-1:0] slot_offs;

    // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        mem_d     = mem_q;
        push1_idx = wr_ptr_q + (push0_en ? PTR_W'(1) : PTR_W'(0));
        if (push0_en) mem_d[wr_ptr_q] = push0_entry;
        if (push1_en) mem_d[push1_idx] = push1_entry;
        wr_ptr_d = wr_ptr_q + PTR_W'(push0_en) + PTR_W'(push1_en);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop_en);
        count_d  = count_q + CW'(push0_en) + CW'(push1_en) - CW'(pop_en);
    end

    // NOTE: storage is not reset; whether a slot holds live data is decided by count and the pointers.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // A slot is live when its distance from the read pointer is below count.
    always_comb begin
        entry_valid = '0;
        entry_rd    = '0;
        slot_offs   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            slot_offs[i]   = PTR_W'(i) - rd_ptr_q;
            entry_valid[i] = CW'(slot_offs[i]) < count_q;
            entry_rd[i]    = mem_q[i].rd;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/wb_write_initiator.sv
// Write-back initiator: buffers ALU/load results and drives the register-file
// write port one entry at a time, holding each write until the file acknowledges.
module wb_write_initiator
    import wb_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 8,
    parameter int CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 alu_valid,
    input  logic [REG_AW-1:0]    alu_rd,
    input  logic [DATA_W-1:0]    alu_data,
    output logic                 alu_ready,
    input  logic                 mem_valid,
    input  logic [REG_AW-1:0]    mem_rd,
    input  logic [DATA_W-1:0]    mem_data,
    output logic                 mem_ready,
    output logic [REG_AW-1:0]    rf_rd,
    output logic [DATA_W-1:0]    rf_data,
    output logic                 rf_write,
    input  logic                 rf_write_finish,
    output logic [NUM_REGS-1:0]  pending_mask,
    output logic                 busy,
    output logic                 err_timeout,
    output logic [CNT_W-1:0]     wr_count
);

    localparam int FCW = $clog2(DEPTH + 1);
    localparam int TW  = $clog2(TIMEOUT + 1);

    wb_state_t              state_q, state_d;
    logic [TW-1:0]          timer_q, timer_d;
    logic [REG_AW-1:0]      rf_rd_q, rf_rd_d;
    logic [DATA_W-1:0]      rf_data_q, rf_data_d;
    logic                   err_q, err_d;
    logic [CNT_W-1:0]       wr_count_q, wr_count_d;

    logic                   push0, push1, pop;
    wb_entry_t              mem_entry, alu_entry, head;
    logic [FCW-1:0]         fifo_count;
    logic [DEPTH-1:0]       ent_valid;
    logic [DEPTH-1:0][REG_AW-1:0] ent_rd;

    // Ready is derived from the registered count only; a same-cycle pop does not free a slot.
    always_comb begin
        mem_ready = fifo_count < FCW'(DEPTH);
        alu_ready = ({1'b0, fifo_count} + (FCW+1)'(mem_valid)) < (FCW+1)'(DEPTH);
        push0     = mem_valid & mem_ready & (mem_rd != '0);
        push1     = alu_valid & alu_ready & (alu_rd != '0);
        mem_entry = '{rd: mem_rd, data: mem_data};
        alu_entry = '{rd: alu_rd, data: alu_data};
    end

    // Load path owns slot 0 so it is enqueued ahead of a same-cycle ALU result.
    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push0_en    (push0),
        .push0_entry (mem_entry),
        .push1_en    (push1),
        .push1_entry (alu_entry),
        .pop_en      (pop),
        .head        (head),
        .count       (fifo_count),
        .entry_valid (ent_valid),
        .entry_rd    (ent_rd)
    );

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        rf_rd_d    = rf_rd_q;
        rf_data_d  = rf_data_q;
        err_d      = err_q;
        wr_count_d = wr_count_q;
        pop        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (fifo_count != '0) begin
                    pop       = 1'b1;
                    rf_rd_d   = head.rd;
                    rf_data_d = head.data;
                    state_d   = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (rf_write_finish) begin
                    wr_count_d = wr_count_q + CNT_W'(1);
                    state_d    = ST_RELEASE;
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = ST_RELEASE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            // One low cycle lets the level-coupled finish drop before the next write.
            ST_RELEASE: begin
                timer_d = '0;
                state_d = ST_IDLE;
            end
            default: begin
                timer_d = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            timer_q    <= '0;
            rf_rd_q    <= '0;
            rf_data_q  <= '0;
            err_q      <= 1'b0;
            wr_count_q <= '0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            rf_rd_q    <= rf_rd_d;
            rf_data_q  <= rf_data_d;
            err_q      <= err_d;
            wr_count_q <= wr_count_d;
        end
    end

    // Queued slots plus the in-flight entry; r0 is never a real destination.
    always_comb begin
        pending_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_valid[i]) pending_mask = pending_mask | rd_onehot(ent_rd[i]);
        end
        if (state_q != ST_IDLE) pending_mask = pending_mask | rd_onehot(rf_rd_q);
        pending_mask[0] = 1'b0;
    end

    assign rf_write    = (state_q == ST_WRITE);
    assign rf_rd       = rf_rd_q;
    assign rf_data     = rf_data_q;
    assign err_timeout = err_q;
    assign wr_count    = wr_count_q;
    assign busy        = (fifo_count != '0) | (state_q != ST_IDLE);

endmodule
